// File: rtl/prbs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prbs_pkg : shared PRBS constants, checker state type, helpers        |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package prbs_pkg;

    localparam int PRBS_LEN = 8;
    localparam int TAP_A    = 6;
    localparam int TAP_B    = 7;
    localparam int WIN_LEN  = 32;

    localparam int WIN_W  = $clog2(WIN_LEN);
    // Fill must be able to hold the value PRBS_LEN itself, hence the extra bit.
    localparam int FILL_W = $clog2(PRBS_LEN) + 1;

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    function automatic logic [PRBS_LEN-1:0] shift_in(
        input logic [PRBS_LEN-1:0] hist,
        input logic                bit_in
    );
        return {hist[PRBS_LEN-2:0], bit_in};
    endfunction

endpackage
`default_nettype wire

// File: rtl/prbs_predict.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prbs_predict : next-bit prediction from the PRBS history register    |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module prbs_predict
    import prbs_pkg::*;
(
    input  logic [PRBS_LEN-1:0] i_hist,
    output logic                o_exp
);

    assign o_exp = i_hist[TAP_A] ^ i_hist[TAP_B];

endmodule
`default_nettype wire

// File: rtl/prbs_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prbs_checker : self-synchronising PRBS checker with flywheel lock    |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_THRESH = 16,
    parameter int UNLOCK_ERRS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        din,
    input  logic        clr,
    output logic        locked,
    output logic        err,
    output logic [15:0] err_count
);

    localparam logic [7:0]        c_lock_thresh = 8'(LOCK_THRESH);
    localparam logic [WIN_W:0]    c_unlock_errs = (WIN_W+1)'(UNLOCK_ERRS);
    localparam logic [WIN_W-1:0]  c_win_last    = WIN_W'(WIN_LEN - 1);
    localparam logic [FILL_W-1:0] c_fill_full   = FILL_W'(PRBS_LEN);

    state_t                state_q, state_d;
    logic [PRBS_LEN-1:0]   hist_q, hist_d;
    logic [FILL_W-1:0]     fill_q, fill_d;
    logic [7:0]            match_cnt_q, match_cnt_d;
    logic [WIN_W-1:0]      win_cnt_q, win_cnt_d;
    logic [WIN_W:0]        win_errs_q, win_errs_d;
    logic                  err_q, err_d;
    logic [15:0]           err_count_q, err_count_d;

    logic                  w_exp;
    logic                  w_err_bit;
    logic [WIN_W:0]        w_errs_sum;

    prbs_predict u_predict (
        .i_hist (hist_q),
        .o_exp  (w_exp)
    );

    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        fill_d      = fill_q;
        match_cnt_d = match_cnt_q;
        win_cnt_d   = win_cnt_q;
        win_errs_d  = win_errs_q;
        err_count_d = err_count_q;
        w_err_bit   = 1'b0;
        w_errs_sum  = win_errs_q;

        if (en) begin
            if (state_q == SEARCH) begin
                hist_d = shift_in(hist_q, din);
                if (fill_q < c_fill_full) begin
                    fill_d = fill_q + 1'b1;
                end else if ((din == w_exp) && (hist_q != '0)) begin
                    // An all-zero history trivially predicts itself; never count it.
                    if (match_cnt_q + 8'd1 == c_lock_thresh) begin
                        state_d     = LOCKED;
                        match_cnt_d = '0;
                        win_cnt_d   = '0;
                        win_errs_d  = '0;
                    end else begin
                        match_cnt_d = match_cnt_q + 8'd1;
                    end
                end else begin
                    match_cnt_d = '0;
                end
            end else begin
                // Flywheel: keep the local sequence running so errors cannot corrupt it.
                hist_d     = shift_in(hist_q, w_exp);
                w_err_bit  = (din != w_exp);
                w_errs_sum = win_errs_q + {{WIN_W{1'b0}}, w_err_bit};
                win_cnt_d  = win_cnt_q + 1'b1;
                if (w_errs_sum >= c_unlock_errs) begin
                    state_d     = SEARCH;
                    fill_d      = '0;
                    match_cnt_d = '0;
                    win_cnt_d   = '0;
                    win_errs_d  = '0;
                end else if (win_cnt_q == c_win_last) begin
                    win_errs_d = '0;
                end else begin
                    win_errs_d = w_errs_sum;
                end
            end

            if (clr) begin
                err_count_d = {15'd0, w_err_bit};
            end else if (w_err_bit && (err_count_q != 16'hFFFF)) begin
                err_count_d = err_count_q + 16'd1;
            end
        end

        err_d = w_err_bit;
    end

    // Reset input is active-high despite its name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= SEARCH;
            hist_q      <= '0;
            fill_q      <= '0;
            match_cnt_q <= '0;
            win_cnt_q   <= '0;
            win_errs_q  <= '0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            match_cnt_q <= match_cnt_d;
            win_cnt_q   <= win_cnt_d;
            win_errs_q  <= win_errs_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign err       = err_q;
    assign err_count = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_prbs_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_prbs_checker : vector table + scoreboard bench for prbs_checker   |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
module tb_prbs_checker;

    typedef struct {
        logic        en;
        logic        flip;
        logic        clr;
        logic        zero;
        logic        lk;
        logic        er;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        logic        lk;
        logic        er;
        logic [15:0] cnt;
        int          id;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        en1 = 1'b0, din1 = 1'b0, clr1 = 1'b0;
    logic        en2 = 1'b0, din2 = 1'b0, clr2 = 1'b0;
    logic        lk1, er1, lk2, er2;
    logic [15:0] cnt1, cnt2;
    logic [7:0]  g1, g2;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    prbs_checker #(.LOCK_THRESH(16), .UNLOCK_ERRS(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en1), .din(din1), .clr(clr1),
        .locked(lk1), .err(er1), .err_count(cnt1)
    );

    prbs_checker #(.LOCK_THRESH(16), .UNLOCK_ERRS(32)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en2), .din(din2), .clr(clr2),
        .locked(lk2), .err(er2), .err_count(cnt2)
    );

    function automatic vec_t mk(input logic en, input logic flip, input logic clr,
                                input logic zero, input logic lk, input logic er,
                                input logic [15:0] cnt);
        vec_t v;
        v.en = en; v.flip = flip; v.clr = clr; v.zero = zero;
        v.lk = lk; v.er = er; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string nm, input int id,
                         input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h, expected %h", nm, id, act, exp);
        end
    endtask

    // Drive one bit at negedge, push expectation, compare just after the next posedge.
    task automatic step(input int inst, input vec_t v, input int id, input bit chk);
        logic b;
        exp_t e;
        @(negedge clk);
        if (v.zero) begin
            b = 1'b0;
        end else if (v.en) begin
            if (inst == 0) begin
                b  = g1[6] ^ g1[7];
                g1 = {g1[6:0], b};
            end else begin
                b  = g2[6] ^ g2[7];
                g2 = {g2[6:0], b};
            end
            b = b ^ v.flip;
        end else begin
            b = 1'($urandom);
        end
        if (inst == 0) begin
            en1 = v.en; din1 = b; clr1 = v.clr;
        end else begin
            en2 = v.en; din2 = b; clr2 = v.clr;
        end
        if (chk) sb.push_back('{v.lk, v.er, v.cnt, id});
        @(posedge clk);
        #1;
        if (chk) begin
            e = sb.pop_front();
            if (inst == 0) begin
                check("locked", e.id, {15'd0, lk1}, {15'd0, e.lk});
                check("err", e.id, {15'd0, er1}, {15'd0, e.er});
                check("err_count", e.id, cnt1, e.cnt);
            end else begin
                check("sat_locked", e.id, {15'd0, lk2}, {15'd0, e.lk});
                check("sat_err", e.id, {15'd0, er2}, {15'd0, e.er});
                check("sat_err_count", e.id, cnt2, e.cnt);
            end
        end
    endtask

    initial begin
        int   lb;
        int   n;
        bit   f;
        bit   c;

        g1 = 8'h01;
        g2 = 8'h01;

        // Reset state
        #12;
        check("rst_locked", 0, {15'd0, lk1}, 16'd0);
        check("rst_err", 0, {15'd0, er1}, 16'd0);
        check("rst_err_count", 0, cnt1, 16'd0);
        @(negedge clk) rst_n = 1'b0;

        // All-zero stream must never lock nor flag errors
        for (int i = 0; i < 200; i++)
            step(0, mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0), 1000 + i, 1'b1);

        @(negedge clk);
        en1   = 1'b0;
        rst_n = 1'b1;
        @(negedge clk) rst_n = 1'b0;
        g1 = 8'h01;

        // Lock from reset: 8 fill + 16 matches
        for (int i = 1; i <= 24; i++)
            vecs.push_back(mk(1, 0, 0, 0, logic'(i == 24), 0, 16'd0));
        for (int i = 0; i < 1000; i++)
            vecs.push_back(mk(1, 0, 0, 0, 1, 0, 16'd0));
        // Single error while locked
        vecs.push_back(mk(1, 1, 0, 0, 1, 1, 16'd1));
        for (int i = 0; i < 40; i++)
            vecs.push_back(mk(1, 0, 0, 0, 1, 0, 16'd1));
        // Clear with no error
        vecs.push_back(mk(1, 0, 1, 0, 1, 0, 16'd0));
        // Four errors within one window: lock drops on the fourth
        vecs.push_back(mk(1, 1, 0, 0, 1, 1, 16'd1));
        vecs.push_back(mk(1, 1, 0, 0, 1, 1, 16'd2));
        vecs.push_back(mk(1, 1, 0, 0, 1, 1, 16'd3));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 16'd4));
        for (int i = 1; i <= 24; i++)
            vecs.push_back(mk(1, 0, 0, 0, logic'(i == 24), 0, 16'd4));
        // en low: everything holds
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(0, 0, 0, 0, 1, 0, 16'd4));
        for (int i = 0; i < 20; i++)
            vecs.push_back(mk(1, 0, 0, 0, 1, 0, 16'd4));
        // clr with a same-cycle error
        vecs.push_back(mk(1, 1, 1, 0, 1, 1, 16'd1));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1, 0, 0, 0, 1, 0, 16'd1));

        foreach (vecs[i]) step(0, vecs[i], i, 1'b1);

        // Asynchronous reset mid-stream while locked
        @(negedge clk);
        en1 = 1'b0;
        #2 rst_n = 1'b1;
        #1;
        check("async_locked", 0, {15'd0, lk1}, 16'd0);
        check("async_err", 0, {15'd0, er1}, 16'd0);
        check("async_err_count", 0, cnt1, 16'd0);
        @(negedge clk) rst_n = 1'b0;

        // Saturation on the wide-window instance: 31 errors per 32-bit window
        for (int i = 1; i <= 24; i++)
            step(1, mk(1, 0, 0, 0, logic'(i == 24), 0, 16'd0), 5000 + i, 1'b1);
        lb = 0;
        n  = 0;
        while (n < 65540) begin
            f = ((lb % 32) != 31);
            if (f) n++;
            c = f && ((n <= 2) || (n % 8192 == 0) || (n >= 65534));
            step(1, mk(1, f, 0, 0, 1, f, (n > 65535) ? 16'hFFFF : 16'(n)), n, c);
            lb++;
        end
        while ((lb % 32) != 0) begin
            step(1, mk(1, 0, 0, 0, 1, 0, 16'hFFFF), 70000 + lb, 1'b1);
            lb++;
        end
        step(1, mk(1, 1, 1, 0, 1, 1, 16'd1), 80000, 1'b1);
        step(1, mk(1, 0, 0, 0, 1, 0, 16'd1), 80001, 1'b1);

        @(negedge clk);
        en2  = 1'b0;
        clr2 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
